// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit path:
//            frame FSM state encoding, parity mode codes, parity helper.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Frame FSM states, fixed encoding so debug probes read consistently
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // parity_mode codes; code 3 is reserved and behaves as no parity
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Parity bit for a zero-padded payload: XOR of the data, inverted for odd
    function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

    // True when the mode inserts a parity bit into the frame
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous FIFO with registered occupancy count. A push is only
//            accepted when the registered count shows room, so a pop in the
//            same cycle never makes room for a write into a full FIFO.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = push_i && (count_q < c_DEPTH_CNT);
    assign w_pop_ok  = pop_i && (count_q != '0);

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == c_DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Storage array; written only on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_sender
// Purpose  : UART transmitter fed from a TX FIFO. Serialises queued words with
//            optional parity and one or two stop bits, oversampled by
//            baud_tick, and chains frames back-to-back while data is queued.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo_sender
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_en,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 uart_tx,
    output logic                 tx_status,
    output logic                 tx_ready,
    output logic                 tx_overflow
);

    localparam int                  c_TICK_W    = $clog2(OVERSAMPLE);
    localparam int                  c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]          c_BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);

    // FIFO interface
    logic [DATA_BITS-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_pop;
    logic [7:0]           w_head_pad;

    // Frame state
    tx_state_e            state_q;
    logic [c_TICK_W-1:0]  tick_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q;
    logic                 par_en_q;
    logic                 two_stop_q;
    logic                 stop_idx_q;
    logic                 uart_tx_q;
    logic                 tx_status_q;
    logic                 tx_ready_q;
    logic                 tx_overflow_q;

    logic                 w_bit_end;
    logic                 w_last_stop;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_en),
        .wdata_i (tx_data),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Zero-pad the head word so the parity helper sees a fixed 8-bit value
    always_comb begin
        w_head_pad                = '0;
        w_head_pad[DATA_BITS-1:0] = w_head;
    end

    assign w_bit_end   = baud_tick && (tick_cnt_q == c_TICK_LAST);
    assign w_last_stop = (stop_idx_q == two_stop_q);

    // Pop (and start a frame) from IDLE on any tick, or at the end of the
    // final stop bit so the next start bit follows with no idle gap
    assign w_pop = baud_tick && !w_empty &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_STOP) && w_bit_end && w_last_stop));

    // Frame FSM with tick counter, bit counter, shift register and line driver
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
            uart_tx_q  <= 1'b1;
        end else if (w_pop) begin
            // Frame settings are captured here and held until the next pop
            state_q    <= ST_START;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= w_head;
            par_bit_q  <= calc_parity(w_head_pad, parity_mode);
            par_en_q   <= parity_enabled(parity_mode);
            two_stop_q <= two_stop;
            stop_idx_q <= 1'b0;
            uart_tx_q  <= 1'b0;
        end else if (baud_tick && (state_q != ST_IDLE)) begin
            if (!w_bit_end) begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end else begin
                tick_cnt_q <= '0;
                case (state_q)
                    ST_START: begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        uart_tx_q <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx_q == c_BIT_LAST) begin
                            if (par_en_q) begin
                                state_q   <= ST_PARITY;
                                uart_tx_q <= par_bit_q;
                            end else begin
                                state_q    <= ST_STOP;
                                stop_idx_q <= 1'b0;
                                uart_tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            uart_tx_q <= shift_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state_q    <= ST_STOP;
                        stop_idx_q <= 1'b0;
                        uart_tx_q  <= 1'b1;
                    end
                    ST_STOP: begin
                        // A non-empty FIFO at the last stop bit is handled by w_pop
                        if (!w_last_stop) begin
                            stop_idx_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                        uart_tx_q <= 1'b1;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        uart_tx_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Status flags, registered from the current cycle's FSM state and FIFO count
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_status_q   <= 1'b1;
            tx_ready_q    <= 1'b1;
            tx_overflow_q <= 1'b0;
        end else begin
            tx_status_q   <= (state_q == ST_IDLE) && w_empty && !tx_en;
            tx_ready_q    <= (w_count < c_DEPTH_CNT);
            tx_overflow_q <= tx_en && w_full;
        end
    end

    assign uart_tx     = uart_tx_q;
    assign tx_status   = tx_status_q;
    assign tx_ready    = tx_ready_q;
    assign tx_overflow = tx_overflow_q;

endmodule
`default_nettype wire
